// File: rtl/aes_shim_pkg.sv
// Shared types and constants for the aes_word_shim word-serial AES front/back end.
// Optional key-reuse bursts are enabled by defining AES_SHIM_KEY_REUSE_EN.
package aes_shim_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } shim_state_e;

    localparam logic [2:0] KEY_W0     = 3'd0;
    localparam logic [2:0] PT_W0      = 3'd4;
    localparam int         NWORDS_OUT = 4;

    // Slot 0 is the most significant word of the 128-bit block.
    function automatic logic [127:0] put_word(input logic [127:0] blk,
                                              input logic [1:0]   slot,
                                              input logic [31:0]  w);
        logic [127:0] r;
        r = blk;
        r[127 - 32*int'(slot) -: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] blk,
                                             input logic [1:0]   slot);
        return blk[127 - 32*int'(slot) -: 32];
    endfunction

endpackage

// File: rtl/aes_shim_ser.sv
// 128->32 output serializer: captures the core ciphertext once and drains it
// MS word first over a valid/ready handshake.
module aes_shim_ser
    import aes_shim_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [127:0] cap_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic         done
);

    localparam logic [1:0] LAST = 2'(NWORDS_OUT - 1);

    logic [127:0] cap_q;
    logic [1:0]   idx;

    assign done = out_valid && out_ready && (idx == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q     <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (capture) begin
            cap_q     <= cap_in;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= get_word(cap_in, 2'd0);
        end else if (out_valid && out_ready) begin
            if (idx == LAST) begin
                idx       <= '0;
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                idx      <= idx + 2'd1;
                out_data <= get_word(cap_q, idx + 2'd1);
            end
        end
    end

endmodule

// File: rtl/aes_word_shim.sv
// Word-serial front/back end for the pipelined aes_128 core: loads key/plaintext
// words, waits the core latency, drains the ciphertext. Option: AES_SHIM_KEY_REUSE_EN.
module aes_word_shim
    import aes_shim_pkg::*;
#(
    parameter int AES_LATENCY = 21,
    parameter int WORD_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
`ifdef AES_SHIM_KEY_REUSE_EN
    input  logic              in_key_keep,
`endif
    output logic [127:0]      aes_state,
    output logic [127:0]      aes_key,
    input  logic [127:0]      aes_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              busy
);

    localparam logic [7:0] LAT_LAST = 8'(AES_LATENCY - 1);

    shim_state_e  state;
    logic [2:0]   word_cnt;
    logic [7:0]   lat_cnt;
    logic [127:0] key_sh;
    logic [127:0] pt_sh;
    logic         keep_q;
    logic         keep_now;
    logic [2:0]   wr_idx;
    logic         in_fire;
    logic         capture;
    logic         done;

`ifdef AES_SHIM_KEY_REUSE_EN
    assign keep_now = in_key_keep && (word_cnt == KEY_W0);
`else
    assign keep_now = 1'b0;
`endif

    // A key-keep burst starts directly at the first plaintext slot.
    assign wr_idx  = keep_now ? PT_W0 : word_cnt;
    assign in_fire = in_valid && in_ready;
    assign capture = (state == WAIT) && (lat_cnt == LAT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            word_cnt  <= KEY_W0;
            lat_cnt   <= '0;
            key_sh    <= '0;
            pt_sh     <= '0;
            keep_q    <= 1'b0;
            aes_key   <= '0;
            aes_state <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (wr_idx[2]) pt_sh  <= put_word(pt_sh,  wr_idx[1:0], in_data);
                        else           key_sh <= put_word(key_sh, wr_idx[1:0], in_data);
                        if (word_cnt == KEY_W0) keep_q <= keep_now;
                        // Core inputs change only once the whole block is in hand.
                        if (wr_idx == 3'd7) begin
                            aes_state <= put_word(pt_sh, 2'd3, in_data);
                            if (!keep_q) aes_key <= key_sh;
                            word_cnt  <= KEY_W0;
                            lat_cnt   <= '0;
                            state     <= WAIT;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            word_cnt <= wr_idx + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_cnt == LAT_LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (done) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    aes_shim_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .cap_in    (aes_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done)
    );

endmodule

// File: tb/tb_aes_word_shim.sv
// Self-checking bench for aes_word_shim with a latency-21 core model and scoreboard.
module tb_aes_word_shim;

    localparam int LAT = 21;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_key_keep;
    logic [127:0] aes_state;
    logic [127:0] aes_key;
    logic [127:0] aes_out;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    logic         override_en  = 1'b0;
    logic [127:0] override_val = '0;
    logic [127:0] pipe [LAT-1];

    always #5 clk = ~clk;

    aes_word_shim #(.AES_LATENCY(LAT), .WORD_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
`ifdef AES_SHIM_KEY_REUSE_EN
        .in_key_keep (in_key_keep),
`endif
        .aes_state   (aes_state),
        .aes_key     (aes_key),
        .aes_out     (aes_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    // Stand-in cipher: exact FIPS-197 answer for the known vector, a keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return {k[63:0], k[127:64]} ^ {p[95:0], p[127:96]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
    endfunction

    // Core model: inputs seen in cycle 1 appear on aes_out in cycle LAT.
    always @(posedge clk) begin
        pipe[0] <= override_en ? override_val : core_fn(aes_key, aes_state);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign aes_out = pipe[LAT-2];

    task automatic push_word(input logic [31:0] w, input bit gap);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        vectors++;
        if (acc !== 1'b1) begin
            miscompares++;
            $display("FAIL push_accept: in_ready=%b, expected word %h accepted", in_ready, w);
        end
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_latency(input logic [127:0] key, input logic [127:0] pt, input bit poke);
        int k;
        k = 0;
        while (!out_valid && k < 300) begin
            vectors++;
            if ({busy, in_ready} !== 2'b10 || aes_key !== key || aes_state !== pt) begin
                miscompares++;
                $display("FAIL wait_hold: busy/in_ready=%b%b key=%h state=%h, expected 10 %h %h",
                         busy, in_ready, aes_key, aes_state, key, pt);
            end
            if (poke && k < 3) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        vectors++;
        if (k !== LAT) begin
            miscompares++;
            $display("FAIL latency: out_valid after %0d cycles, expected %0d", k, LAT);
        end
    endtask

    task automatic load_block(input logic [127:0] key, input logic [127:0] pt,
                              input bit toggle, input bit poke);
        logic [127:0] k0;
        logic [127:0] s0;
        logic [31:0]  w;
        k0 = aes_key;
        s0 = aes_state;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? key[127 - 32*i -: 32] : pt[127 - 32*(i-4) -: 32];
            push_word(w, toggle && (i < 7));
            if (i < 7) begin
                vectors++;
                if (aes_key !== k0 || aes_state !== s0) begin
                    miscompares++;
                    $display("FAIL load_hold word %0d: key=%h state=%h, expected %h %h",
                             i, aes_key, aes_state, k0, s0);
                end
            end
        end
        vectors++;
        if (aes_key !== key || aes_state !== pt) begin
            miscompares++;
            $display("FAIL issue: key=%h state=%h, expected %h %h", aes_key, aes_state, key, pt);
        end
        wait_latency(key, pt, poke);
    endtask

    task automatic drain_block(input logic [127:0] exp, input int stall_word, input int stall_len);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ew;
            ew = exp[127 - 32*i -: 32];
            if (i == stall_word) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    vectors++;
                    if ({out_valid, in_ready} !== 2'b10 || out_data !== ew) begin
                        miscompares++;
                        $display("FAIL stall word %0d: valid/in_ready=%b%b data=%h, expected 10 %h",
                                 i, out_valid, in_ready, out_data, ew);
                    end
                    @(posedge clk);
                    #1;
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready} !== 2'b10 || out_data !== ew) begin
                miscompares++;
                $display("FAIL drain word %0d: valid/in_ready=%b%b data=%h, expected 10 %h",
                         i, out_valid, in_ready, out_data, ew);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL drain_end: valid/in_ready/busy=%b%b%b data=%h, expected 010 0",
                     out_valid, in_ready, busy, out_data);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'h0 ||
            aes_key !== 128'h0 || aes_state !== 128'h0) begin
            miscompares++;
            $display("FAIL %s: ready/valid/busy=%b%b%b data=%h key=%h state=%h, expected 100 and zeros",
                     tag, in_ready, out_valid, busy, out_data, aes_key, aes_state);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_key_keep = 1'b0;
        out_ready = 1'b0;
        #2;
        check_reset_values("reset_state");
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fips;
        load_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0);
        drain_block(FIPS_CT, -1, 0);
    endtask

    task automatic test_stall;
        load_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0);
        drain_block(FIPS_CT, 2, 5);
    endtask

    task automatic test_toggle_load;
        load_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1);
        drain_block(FIPS_CT, -1, 0);
    endtask

    task automatic test_reset_abort;
        logic [127:0] k;
        logic [127:0] p;
        for (int i = 0; i < 5; i++)
            push_word((i < 4) ? FIPS_KEY[127 - 32*i -: 32] : 32'hdead_beef, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("reset_mid_load");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        load_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0);
        drain_block(FIPS_CT, -1, 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        load_block(k, p, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("reset_in_drain");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        override_en = 1'b1;
        for (int b = 1; b <= 2; b++) begin
            override_val = 128'(b);
            load_block({$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            drain_block(128'(b), -1, 0);
        end
        override_en = 1'b0;
    endtask

    task automatic test_random;
        logic [127:0] k;
        logic [127:0] p;
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            load_block(k, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain_block(core_fn(k, p), $urandom_range(0, 3), $urandom_range(0, 4));
        end
    endtask

`ifdef AES_SHIM_KEY_REUSE_EN
    task automatic test_key_reuse;
        logic [127:0] p;
        load_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0);
        drain_block(FIPS_CT, -1, 0);
        for (int r = 0; r < 2; r++) begin
            p = (r == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                in_key_keep = (i == 0);
                push_word(p[127 - 32*i -: 32], 1'b0);
                in_key_keep = 1'b0;
                vectors++;
                if (in_ready !== (i < 3)) begin
                    miscompares++;
                    $display("FAIL keep_count word %0d: in_ready=%b, expected %b", i, in_ready, (i < 3));
                end
            end
            vectors++;
            if (aes_key !== FIPS_KEY || aes_state !== p) begin
                miscompares++;
                $display("FAIL keep_issue: key=%h state=%h, expected %h %h", aes_key, aes_state, FIPS_KEY, p);
            end
            wait_latency(FIPS_KEY, p, 1'b0);
            drain_block(core_fn(FIPS_KEY, p), -1, 0);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips();
        test_stall();
        test_toggle_load();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef AES_SHIM_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
